sonic_tx_unpack_128_66: RTL and testbench

SONIC_TX_UNPACK_128_66 -- requirements
Module: sonic_tx_unpack_128_66

---
 rtl/sonic_tx_pkg.sv | 21 ++
 rtl/sonic_tx_bit_accumulator.sv | 52 +++++
 rtl/sonic_tx_unpack_128_66.sv | 101 ++++++++++
 tb/tb_sonic_tx_unpack_128_66.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sonic_tx_pkg.sv
// sonic_tx_pkg -- shared widths, IDLE block and FSM state type for the
// SONIC TX 128->66 unpacker.
package sonic_tx_pkg;

  localparam int TX_WORD_W  = 128;
  localparam int TX_BLOCK_W = 66;
  localparam int TX_ACC_W   = 256;
  localparam int TX_CNT_W   = 9;              // holds 0..256
  localparam int TX_PRIME_BITS = 2 * TX_BLOCK_W; // two full blocks before RUN

  // Header 2'b01 in [1:0], block type 8'h1E in [9:2], everything else 0.
  localparam logic [TX_BLOCK_W-1:0] SONIC_IDLE_BLOCK_66 =
    {56'h0, 8'h1E, 2'b01};

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2
  } tx_unpack_state_t;

endpackage

// File: rtl/sonic_tx_bit_accumulator.sv
// sonic_tx_bit_accumulator -- 256-bit LSB-first bit FIFO.
// Ports:
//   clock, reset  : clock, async active-low reset
//   clear         : synchronous flush (cnt -> 0, contents become don't-care)
//   push, din     : append 128 bits above the bits still held
//   pop           : drop the oldest 66 bits (caller guarantees cnt >= 66)
//   head          : oldest 66 bits, acc[65:0]
//   cnt           : number of valid bits held
module sonic_tx_bit_accumulator
  import sonic_tx_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [TX_WORD_W-1:0]  din,
  output logic [TX_BLOCK_W-1:0] head,
  output logic [TX_CNT_W-1:0]   cnt
);

  logic [TX_ACC_W-1:0] acc;
  logic [TX_ACC_W-1:0] shifted;
  logic [TX_ACC_W-1:0] keep_mask;
  logic [TX_ACC_W-1:0] ins;
  logic [TX_CNT_W-1:0] base;

  // The pop is applied first, so a same-cycle push lands directly above the
  // bits that survive the pop; nothing is lost or duplicated.
  always_comb begin
    base      = pop ? cnt - TX_CNT_W'(TX_BLOCK_W) : cnt;
    shifted   = pop ? (acc >> TX_BLOCK_W) : acc;
    // Stale bits above cnt (e.g. after a clear) must not leak into the OR.
    keep_mask = (TX_ACC_W'(1) << base) - TX_ACC_W'(1);
    ins       = TX_ACC_W'(din) << base;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (push || pop) begin
      acc <= push ? ((shifted & keep_mask) | ins) : shifted;
      cnt <= base + (push ? TX_CNT_W'(TX_WORD_W) : TX_CNT_W'(0));
    end
  end

  assign head = acc[TX_BLOCK_W-1:0];

endmodule

// File: rtl/sonic_tx_unpack_128_66.sv
// sonic_tx_unpack_128_66 -- converts a 128-bit DMA word stream (LSB first)
// into 66-bit blocks for the TX gearbox.
// Ports:
//   clock, reset          : clock, async active-low reset
//   ena                   : enable_sfp && xcvr_ready
//   data_in, wrreq        : DMA word in, accepted when wrreq && wr_ready
//   wr_ready              : room for one more 128-bit word
//   data_out, data_valid  : 66-bit block out ([1:0] sync header)
//   rdreq                 : gearbox takes the block when data_valid && rdreq
//   level                 : bits currently buffered
//   underflow_count       : saturating count of RUN cycles with rdreq and < 66 bits
//   sync_error            : pulse the cycle after a buffered block with header
//                           2'b00 / 2'b11 is transferred
// Build option: SONIC_TX_IDLE_INSERT_EN -- substitute IDLE blocks on underflow.
module sonic_tx_unpack_128_66
  import sonic_tx_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [TX_WORD_W-1:0]  data_in,
  input  logic                  wrreq,
  output logic                  wr_ready,
  output logic [TX_BLOCK_W-1:0] data_out,
  output logic                  data_valid,
  input  logic                  rdreq,
  output logic [TX_CNT_W-1:0]   level,
  output logic [31:0]           underflow_count,
  output logic                  sync_error
);

  tx_unpack_state_t state, state_nxt;

  logic [TX_CNT_W-1:0]   cnt;
  logic [TX_BLOCK_W-1:0] head;
  logic                  blk_avail;
  logic                  push;
  logic                  pop;
  logic                  underflow;
  logic                  clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= DISABLED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DISABLED: if (ena) state_nxt = PRIME;
      PRIME: begin
        if (!ena)                                  state_nxt = DISABLED;
        else if (cnt >= TX_CNT_W'(TX_PRIME_BITS)) state_nxt = RUN;
      end
      RUN:     if (!ena) state_nxt = DISABLED;
      default: state_nxt = DISABLED;
    endcase
  end

  assign wr_ready  = (state != DISABLED) && (cnt <= TX_CNT_W'(TX_WORD_W));
  assign push      = wrreq && wr_ready;
  assign blk_avail = (state == RUN) && (cnt >= TX_CNT_W'(TX_BLOCK_W));
  assign pop       = blk_avail && rdreq;
  assign underflow = (state == RUN) && rdreq && (cnt < TX_CNT_W'(TX_BLOCK_W));
  // Dropping ena flushes in the same edge that leaves PRIME/RUN.
  assign clear     = (state == DISABLED) || !ena;
  assign level     = cnt;

  sonic_tx_bit_accumulator u_acc (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .head  (head),
    .cnt   (cnt)
  );

`ifdef SONIC_TX_IDLE_INSERT_EN
  // IDLE fill is output-only: no pop reaches the accumulator, no header check.
  assign data_valid = blk_avail || underflow;
  assign data_out   = blk_avail ? head :
                      underflow ? SONIC_IDLE_BLOCK_66 : '0;
`else
  assign data_valid = blk_avail;
  assign data_out   = blk_avail ? head : '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underflow_count <= '0;
      sync_error      <= 1'b0;
    end else begin
      if (underflow && (underflow_count != 32'hFFFF_FFFF))
        underflow_count <= underflow_count + 32'd1;
      sync_error <= pop && ((head[1:0] == 2'b00) || (head[1:0] == 2'b11));
    end
  end

endmodule

// File: tb/tb_sonic_tx_unpack_128_66.sv
// Directed bench for sonic_tx_unpack_128_66: long in-order stream, underflow
// (with or without IDLE insertion), sync-error pulse, ena drop / re-prime,
// write back-pressure and asynchronous reset.
module tb_sonic_tx_unpack_128_66;
  import sonic_tx_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ena   = 1'b0;
  logic [127:0] data_in = '0;
  logic         wrreq = 1'b0;
  logic         rdreq = 1'b0;
  logic         wr_ready;
  logic [65:0]  data_out;
  logic         data_valid;
  logic [8:0]   level;
  logic [31:0]  underflow_count;
  logic         sync_error;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4223:0] bs;
  localparam logic [127:0] WA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3213;
  localparam logic [127:0] WB = 128'hA5A5_5A5A_0F0F_F0F0_1122_3344_5566_778D;
  localparam logic [65:0]  IDLE_EXP = 66'h079;

  always #5 clock = ~clock;

  sonic_tx_unpack_128_66 dut (
    .clock           (clock),
    .reset           (reset),
    .ena             (ena),
    .data_in         (data_in),
    .wrreq           (wrreq),
    .wr_ready        (wr_ready),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .rdreq           (rdreq),
    .level           (level),
    .underflow_count (underflow_count),
    .sync_error      (sync_error)
  );

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int w, rcv, acc_n;
    logic sync_seen;
    logic [65:0] exp_blk;

    for (int k = 0; k < 64; k++) bs[k*66 +: 66] = {64'(k), 2'b01};

    // reset state, before any clock edge
    ena = 1'b1;
    #3;
    chk("rst_wr_ready",  66'(wr_ready), 66'd0);
    chk("rst_valid",     66'(data_valid), 66'd0);
    chk("rst_data_out",  data_out, 66'd0);
    chk("rst_level",     66'(level), 66'd0);
    chk("rst_underflow", 66'(underflow_count), 66'd0);
    chk("rst_sync_err",  66'(sync_error), 66'd0);
    tick();
    reset = 1'b1;

    // long stream: 33 words -> 64 blocks; keep the last block for underflow test
    w = 0; rcv = 0; sync_seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (sync_error) sync_seen = 1'b1;
      if (rcv == 63 && w == 33) break;
      rdreq = (level >= 9'd66) && (rcv < 63);
      if (data_valid && rdreq) begin
        exp_blk = {64'(rcv), 2'b01};
        chk($sformatf("blk%0d", rcv), data_out, exp_blk);
        rcv++;
      end
      if (wr_ready && w < 33) begin
        wrreq = 1'b1; data_in = bs[w*128 +: 128]; w++;
      end else begin
        wrreq = 1'b0;
      end
      tick();
    end
    wrreq = 1'b0; rdreq = 1'b0;
    chk("long_words_in", 66'(w), 66'd33);
    chk("long_blocks_out", 66'(rcv), 66'd63);
    chk("long_level_66", 66'(level), 66'd66);
    chk("long_no_underflow", 66'(underflow_count), 66'd0);

    // one real block then two underflow cycles
    rdreq = 1'b1; #1;
    chk("uf_real_valid", 66'(data_valid), 66'd1);
    chk("uf_real_blk63", data_out, {64'd63, 2'b01});
    tick();
    for (int i = 0; i < 2; i++) begin
`ifdef SONIC_TX_IDLE_INSERT_EN
      chk("uf_idle_valid", 66'(data_valid), 66'd1);
      chk("uf_idle_block", data_out, IDLE_EXP);
`else
      chk("uf_no_valid", 66'(data_valid), 66'd0);
`endif
      if (sync_error) sync_seen = 1'b1;
      tick();
    end
    rdreq = 1'b0; #1;
    chk("uf_count_2", 66'(underflow_count), 66'd2);
    chk("uf_level_0", 66'(level), 66'd0);
    if (sync_error) sync_seen = 1'b1;
    chk("long_no_sync", 66'(sync_seen), 66'd0);

    // header 2'b11 block -> one-cycle sync_error on the following cycle
    wrreq = 1'b1; data_in = WA;
    tick();
    wrreq = 1'b0; rdreq = 1'b1; #1;
    chk("se_latency_valid", 66'(data_valid), 66'd1);
    chk("se_block", data_out, WA[65:0]);
    chk("se_before", 66'(sync_error), 66'd0);
    tick();
    rdreq = 1'b0;
    chk("se_pulse", 66'(sync_error), 66'd1);
    chk("se_level_62", 66'(level), 66'd62);
    wrreq = 1'b1; data_in = WB;
    tick();
    wrreq = 1'b0;
    chk("se_cleared", 66'(sync_error), 66'd0);

    // ena drop at level 190
    chk("dis_level_190", 66'(level), 66'd190);
    chk("dis_straddle", data_out, {WB[3:0], WA[127:66]});
    ena = 1'b0;
    tick();
    chk("dis_level_0", 66'(level), 66'd0);
    chk("dis_valid_0", 66'(data_valid), 66'd0);
    chk("dis_wr_ready_0", 66'(wr_ready), 66'd0);

    // re-enable: wrreq held, rdreq low -> exactly two words, PRIME until 132 bits
    ena = 1'b1; wrreq = 1'b1; acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      data_in = (acc_n == 0) ? WB : WA;
      if (level == 9'd128) chk("prime_128_no_valid", 66'(data_valid), 66'd0);
      if (wr_ready) acc_n++;
      tick();
    end
    wrreq = 1'b0; #1;
    chk("bp_accepts_2", 66'(acc_n), 66'd2);
    chk("bp_level_256", 66'(level), 66'd256);
    chk("bp_wr_ready_0", 66'(wr_ready), 66'd0);
    chk("bp_run_valid", 66'(data_valid), 66'd1);
    chk("bp_first_blk", data_out, WB[65:0]);

    // three pops, then three underflows -> count 5; then bring level to 120
    rdreq = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rdreq = 1'b0;
    chk("pre_rst_uf_5", 66'(underflow_count), 66'd5);
    chk("pre_rst_level_58", 66'(level), 66'd58);
    wrreq = 1'b1; data_in = WB;
    tick();
    wrreq = 1'b0; rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("pre_rst_level_120", 66'(level), 66'd120);

    // asynchronous reset mid-cycle, checked before the next edge
    #1 reset = 1'b0;
    #1;
    chk("arst_level", 66'(level), 66'd0);
    chk("arst_underflow", 66'(underflow_count), 66'd0);
    chk("arst_wr_ready", 66'(wr_ready), 66'd0);
    chk("arst_valid", 66'(data_valid), 66'd0);
    chk("arst_data_out", data_out, 66'd0);
    chk("arst_sync_err", 66'(sync_error), 66'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("restart_prime_wr_ready", 66'(wr_ready), 66'd1);
    chk("restart_level", 66'(level), 66'd0);
    wrreq = 1'b1; data_in = WA;
    tick();
    wrreq = 1'b0;
    chk("restart_level_128", 66'(level), 66'd128);
    chk("restart_no_valid", 66'(data_valid), 66'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
